gauss3x3_ctrl: RTL

- Frame-level controller for the dual-port gray-image SRAM.
- On `start`, it reads an IMG_W x IMG_H 8-bit gray image from the SRC_BASE region through port A.
- It applies a 3x3 Gaussian kernel [1 2 1; 2 4 2; 1 2 1]/16 to interior pixels and copies border pixels unchanged.
- It writes the result image through port B at DST_BASE. It sits between the top-level test/host sequencer and the SRAM ports.

---
 rtl/gauss3x3_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/gauss3x3_ctrl.sv
// Frame controller: reads a gray image over SRAM port A, applies a 3x3 Gaussian
// to interior pixels (borders copied) and writes the result over port B.
module gauss3x3_ctrl #(
    parameter int IMG_W    = 16,
    parameter int IMG_H    = 16,
    parameter int ADDR_W   = 10,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 512
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              ena,
    output logic              wena,
    output logic [ADDR_W-1:0] addra,
    input  logic [7:0]        qa,
    output logic              enb,
    output logic              wenb,
    output logic [ADDR_W-1:0] addrb,
    output logic [7:0]        db
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [XW-1:0]     x_reg, x_next;
    logic [YW-1:0]     y_reg, y_next;
    logic [3:0]        k_reg, k_next;
    logic [11:0]       acc_reg, acc_next;
    logic              rd_pend_reg, rd_pend_next;
    logic [4:0]        rd_w_reg, rd_w_next;
    logic [ADDR_W-1:0] addra_hold_reg, addrb_hold_reg;
    logic [7:0]        db_hold_reg;

    // Per-tap address offset relative to the centre pixel, and kernel weight.
    logic [ADDR_W-1:0] tap_off [9];
    logic [4:0]        tap_w   [9];

    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_tap
            localparam int DY = gi / 3 - 1;
            localparam int DX = gi % 3 - 1;
            localparam int AY = (DY < 0) ? -DY : DY;
            localparam int AX = (DX < 0) ? -DX : DX;
            assign tap_off[gi] = ADDR_W'(DY * IMG_W + DX);
            assign tap_w[gi]   = 5'((2 - AX) * (2 - AY));
        end
    endgenerate

    logic              interior;
    logic [3:0]        last_k;
    logic [ADDR_W-1:0] pix_off, rd_addr, wr_addr;
    logic [11:0]       prod;

    assign interior = (x_reg != '0) && (x_reg != X_LAST) &&
                      (y_reg != '0) && (y_reg != Y_LAST);
    assign last_k   = interior ? 4'd8 : 4'd0;
    assign pix_off  = ADDR_W'(y_reg) * ADDR_W'(IMG_W) + ADDR_W'(x_reg);
    assign rd_addr  = ADDR_W'(SRC_BASE) + pix_off + (interior ? tap_off[k_reg] : '0);
    assign wr_addr  = ADDR_W'(DST_BASE) + pix_off;
    assign prod     = 12'(qa) * 12'(rd_w_reg);

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        k_next       = k_reg;
        rd_pend_next = 1'b0;
        rd_w_next    = rd_w_reg;
        // qa belongs to the read issued in the previous cycle
        acc_next     = rd_pend_reg ? (acc_reg + prod) : acc_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    x_next     = '0;
                    y_next     = '0;
                    k_next     = '0;
                    state_next = S_READ;
                end
            end
            S_READ: begin
                rd_pend_next = 1'b1;
                rd_w_next    = interior ? tap_w[k_reg] : 5'd16;
                if (k_reg == 4'd0) acc_next = '0;
                if (k_reg == last_k) begin
                    k_next     = '0;
                    state_next = S_WAIT;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end
            S_WAIT: state_next = S_WRITE;
            S_WRITE: begin
                k_next     = '0;
                state_next = S_READ;
                if (x_reg == X_LAST) begin
                    x_next = '0;
                    if (y_reg == Y_LAST) begin
                        y_next     = '0;
                        state_next = S_DONE;
                    end else begin
                        y_next = y_reg + YW'(1);
                    end
                end else begin
                    x_next = x_reg + XW'(1);
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign ena   = (state_reg == S_READ);
    assign wena  = 1'b1;
    assign enb   = (state_reg == S_WRITE);
    assign wenb  = ~enb;
    assign busy  = (state_reg == S_READ) || (state_reg == S_WAIT) || (state_reg == S_WRITE);
    assign done  = (state_reg == S_DONE);
    assign addra = ena ? rd_addr : addra_hold_reg;
    assign addrb = enb ? wr_addr : addrb_hold_reg;
    assign db    = enb ? acc_reg[11:4] : db_hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= S_IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            k_reg          <= '0;
            acc_reg        <= '0;
            rd_pend_reg    <= 1'b0;
            rd_w_reg       <= '0;
            addra_hold_reg <= '0;
            addrb_hold_reg <= '0;
            db_hold_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            k_reg          <= k_next;
            acc_reg        <= acc_next;
            rd_pend_reg    <= rd_pend_next;
            rd_w_reg       <= rd_w_next;
            addra_hold_reg <= addra;
            addrb_hold_reg <= addrb;
            db_hold_reg    <= db;
        end
    end

endmodule
